pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush/halt controller: Moore FSM driving stall, bubble and flush controls.
// Optional PIPE_CTRL_PERF_EN macro adds a saturating bubble-cycle counter on stall_cycles.

module pipe_ctrl #(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [6:0] LOAD_OP      = 7'b0000011
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        br_taken,
  input  logic        mem_ready,
  input  logic [2:0]  rd_src0,
  input  logic [2:0]  rd_src1,
  input  logic        rd_use0,
  input  logic        rd_use1,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_dest,
  output logic        halt_op,
  output logic        clr_sgn,
  output logic        pc_stall,
  output logic        fetch_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  // state | meaning
  // RUN   | normal issue, no bubbles
  // STALL | load-use wait for mem_ready; PC frozen, NOP into execute
  // FLUSH | branch shadow; fetch cleared, NOP into execute for FLUSH_CYCLES
  // HALT  | pipeline frozen until resume

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     cur_st, nxt_st;
  logic [3:0] flush_cnt, flush_cnt_nxt;
  logic       hazard;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = (ex_opcode == LOAD_OP) && (ex_dest != 3'd0) &&
                  ((rd_use0 && (rd_src0 == ex_dest)) ||
                   (rd_use1 && (rd_src1 == ex_dest)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_st    <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      cur_st    <= nxt_st;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    nxt_st        = cur_st;
    flush_cnt_nxt = flush_cnt;
    if (halt_req) begin
      nxt_st        = HALT;
      flush_cnt_nxt = 4'd0;
    end else begin
      case (cur_st)
        RUN: begin
          if (br_taken) begin
            nxt_st        = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end else if (hazard) begin
            nxt_st = STALL;
          end
        end
        STALL: begin
          if (br_taken) begin
            nxt_st        = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end else if (mem_ready) begin
            nxt_st = RUN;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            nxt_st = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
        HALT: begin
          if (resume) begin
            nxt_st = RUN;
          end
        end
        default: nxt_st = RUN;
      endcase
    end
  end

  always_comb begin
    halt_op     = 1'b0;
    clr_sgn     = 1'b0;
    pc_stall    = 1'b0;
    fetch_flush = 1'b0;
    case (cur_st)
      STALL: begin
        pc_stall = 1'b1;
        clr_sgn  = 1'b1;
      end
      FLUSH: begin
        clr_sgn     = 1'b1;
        fetch_flush = 1'b1;
      end
      HALT: begin
        halt_op  = 1'b1;
        pc_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = cur_st;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cnt <= 16'h0000;
    end else if (((cur_st == STALL) || (cur_st == FLUSH)) && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against
// an abstract model tracking mode, remaining flush bubbles and bubble-cycle count.

module tb_pipe_ctrl;
  localparam int         FC = 2;
  localparam logic [6:0] LD = 7'b0000011;

  logic        clk = 1'b0;
  logic        nrst;
  logic        halt_req, resume, br_taken, mem_ready;
  logic [2:0]  rd_src0, rd_src1, ex_dest;
  logic        rd_use0, rd_use1;
  logic [6:0]  ex_opcode;
  logic        halt_op, clr_sgn, pc_stall, fetch_flush;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // model: mode 0=RUN 1=STALL 2=FLUSH 3=HALT, fl_left = flush bubbles still to issue
  int m_mode = 0;
  int m_fl   = 0;
  int m_perf = 0;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .LOAD_OP(LD)) dut (
    .clk(clk), .nrst(nrst), .halt_req(halt_req), .resume(resume),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .rd_src0(rd_src0), .rd_src1(rd_src1), .rd_use0(rd_use0), .rd_use1(rd_use1),
    .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .halt_op(halt_op), .clr_sgn(clr_sgn), .pc_stall(pc_stall),
    .fetch_flush(fetch_flush), .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_hazard();
    return (ex_opcode == LD) && (ex_dest != 0) &&
           ((rd_use0 && rd_src0 == ex_dest) || (rd_use1 && rd_src1 == ex_dest));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fl = 0; m_perf = 0;
  endtask

  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (m_mode == 1 || m_mode == 2) m_perf = (m_perf < 65535) ? m_perf + 1 : 65535;
    if (halt_req) begin
      m_mode = 3; m_fl = 0;
    end else if (m_mode == 0 || m_mode == 1) begin
      if (br_taken) begin
        m_mode = 2; m_fl = FC;
      end else if (m_mode == 0 && hz) m_mode = 1;
      else if (m_mode == 1 && mem_ready) m_mode = 0;
    end else if (m_mode == 2) begin
      m_fl = m_fl - 1;
      if (m_fl == 0) m_mode = 0;
    end else if (resume) begin
      m_mode = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_perf;
`ifdef PIPE_CTRL_PERF_EN
    exp_perf = 16'(m_perf);
`else
    exp_perf = 16'h0000;
`endif
    chk({tag, ".state"}, 16'(state), 16'(m_mode));
    chk({tag, ".halt_op"}, 16'(halt_op), 16'(m_mode == 3));
    chk({tag, ".clr_sgn"}, 16'(clr_sgn), 16'(m_mode == 1 || m_mode == 2));
    chk({tag, ".pc_stall"}, 16'(pc_stall), 16'(m_mode == 1 || m_mode == 3));
    chk({tag, ".fetch_flush"}, 16'(fetch_flush), 16'(m_mode == 2));
    chk({tag, ".stall_cycles"}, stall_cycles, exp_perf);
  endtask

  task automatic step(input string tag, input bit do_chk);
    @(posedge clk);
    model_edge();
    #1;
    if (do_chk) check_all(tag);
  endtask

  task automatic idle_inputs();
    halt_req = 0; resume = 0; br_taken = 0; mem_ready = 0;
    rd_src0 = 0; rd_src1 = 0; rd_use0 = 0; rd_use1 = 0;
    ex_opcode = 7'b0110011; ex_dest = 0;
  endtask

  task automatic set_load_use();
    ex_opcode = LD; ex_dest = 3; rd_src1 = 3; rd_use1 = 1;
  endtask

  initial begin
    idle_inputs();
    nrst = 0;
    #12;
    model_reset();
    check_all("reset");
    @(negedge clk);
    nrst = 1;
    step("idle", 1);

    // load-use stall held for four cycles, then released by mem_ready
    set_load_use();
    for (int i = 0; i < 4; i++) step("lu_stall", 1);
    chk("lu_in_stall", 16'(state), 16'd1);
    idle_inputs();
    mem_ready = 1;
    step("lu_release", 1);
    chk("lu_back_run", 16'(state), 16'd0);
    mem_ready = 0;

    // x0 destination and unused source never stall
    ex_opcode = LD; ex_dest = 0; rd_src0 = 0; rd_use0 = 1;
    step("x0_nohz", 1);
    ex_dest = 5; rd_src0 = 5; rd_use0 = 0;
    step("unused_nohz", 1);
    chk("nohz_run", 16'(state), 16'd0);
    idle_inputs();

    // branch flush, second branch inside the shadow ignored
    br_taken = 1;
    step("br_enter", 1);
    chk("br_flush1", 16'(fetch_flush), 16'd1);
    step("br_ignored", 1);
    chk("br_flush2", 16'(fetch_flush), 16'd1);
    br_taken = 0;
    step("br_done", 1);
    chk("br_exit_run", 16'(state), 16'd0);

    // halt beats branch and hazard together
    set_load_use();
    br_taken = 1; halt_req = 1;
    step("halt_prio", 1);
    chk("halt_no_clr", 16'(clr_sgn), 16'd0);
    idle_inputs();
    step("halt_hold", 1);
    resume = 1;
    step("halt_resume", 1);
    chk("resume_run", 16'(state), 16'd0);
    resume = 0;

    // halt from inside flush abandons remaining bubbles
    br_taken = 1;
    step("br_then_halt", 1);
    br_taken = 0; halt_req = 1;
    step("halt_mid_flush", 1);
    halt_req = 0; resume = 1;
    step("resume_after_flush", 1);
    resume = 0;
    step("post_resume", 1);

    // async reset between edges in the middle of a flush
    br_taken = 1;
    step("pre_rst_flush", 1);
    br_taken = 0;
    #2;
    nrst = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    nrst = 1;
    step("post_rst", 1);

    // random traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      halt_req  = ($urandom_range(0, 19) == 0);
      resume    = ($urandom_range(0, 2) == 0);
      br_taken  = ($urandom_range(0, 7) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      ex_opcode = ($urandom_range(0, 1) == 0) ? LD : 7'($urandom);
      ex_dest   = 3'($urandom);
      rd_src0   = 3'($urandom);
      rd_src1   = 3'($urandom);
      rd_use0   = 1'($urandom);
      rd_use1   = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        nrst = 0;
        #1;
        model_reset();
        check_all("rnd_rst");
        #1;
        nrst = 1;
      end
      step("rnd", 1);
    end

`ifdef PIPE_CTRL_PERF_EN
    // long forced stall to drive the counter into saturation
    idle_inputs();
    nrst = 0;
    #1;
    model_reset();
    #1;
    nrst = 1;
    set_load_use();
    for (int i = 0; i < 65540; i++) step("sat", 0);
    check_all("sat_end");
    chk("sat_value", stall_cycles, 16'hFFFF);
    step("sat_hold", 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
